// File: rtl/sr_latch_driver_if.sv
// Request/status bundle between control logic, sr_latch_driver and the RS latch.
// The master side drives the requests and the latch readback.
// The slave side is the driver itself.
interface sr_latch_driver_if;
  logic req_set;
  logic req_clr;
  logic q;
  logic q_bar;
  logic set_out;
  logic reset_out;
  logic ready;
  logic done;
  logic err;
  logic conflict;
  logic drop;
  logic state_exp;

  modport master (
    output req_set, req_clr, q, q_bar,
    input  set_out, reset_out, ready, done, err, conflict, drop, state_exp
  );

  modport slave (
    input  req_set, req_clr, q, q_bar,
    output set_out, reset_out, ready, done, err, conflict, drop, state_exp
  );
endinterface

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: pulses the set/reset inputs of an external NOR RS latch,
// then reads the latch back through a 2-flop synchronizer and reports done/err.
// Optional feature macro: SRDRV_RETRY_EN. When it is defined, a readback
// mismatch re-issues the same pulse, up to MAX_RETRY extra times, before err is reported.
//
// state  | meaning
// IDLE   | ready=1, waiting for a single set or clear request
// PULSE  | set_out or reset_out high for PULSE_CYCLES
// SETTLE | both drives low, latch output propagating through the synchronizer
// CHECK  | done/err valid this cycle (or a retry is pending)
// GAP    | both drives low guard time before ready returns
module sr_latch_driver #(
  parameter int CNT_W         = 4,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1,
  parameter int MAX_RETRY     = 2
) (
  input  logic               clk,
  input  logic               rst,
  sr_latch_driver_if.slave   bus
);

  // Reject parameter sets whose load values do not fit the phase counter.
  if (CNT_W < 1 ||
      PULSE_CYCLES < 1 || PULSE_CYCLES > (1 << CNT_W) - 1 ||
      SETTLE_CYCLES < 2 || SETTLE_CYCLES > (1 << CNT_W) - 1 ||
      GAP_CYCLES < 1 || GAP_CYCLES > (1 << CNT_W) - 1 ||
      MAX_RETRY < 0) begin : g_bad_param
    $error("sr_latch_driver: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PULSE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    GAP    = 3'd4
  } state_t;

  // The counter holds "cycles remaining minus one" for the current phase.
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic set_r;
  logic reset_r;
  logic ready_r;
  logic done_r;
  logic err_r;
  logic conflict_r;
  logic drop_r;
  logic state_exp_r;

  logic q_meta;
  logic q_sync;
  logic qb_meta;
  logic qb_sync;
  logic readback_ok;
  logic any_req;
  logic cnt_zero;

`ifdef SRDRV_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  logic [RETRY_W-1:0] retry_cnt;
  logic               retry_pending;
`endif

  // Bring the asynchronous latch outputs into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_meta  <= 1'b0;
      q_sync  <= 1'b0;
      qb_meta <= 1'b0;
      qb_sync <= 1'b0;
    end else begin
      q_meta  <= bus.q;
      q_sync  <= q_meta;
      qb_meta <= bus.q_bar;
      qb_sync <= qb_meta;
    end
  end

  // Only the exact complementary pair matching the command is a good readback;
  // 00 and 11 both count as mismatches.
  assign readback_ok = state_exp_r ? ( q_sync & ~qb_sync)
                                   : (~q_sync &  qb_sync);
  assign any_req     = bus.req_set | bus.req_clr;
  assign cnt_zero    = (cnt == '0);

  // Sequencer: phase transitions, phase counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      set_r       <= 1'b0;
      reset_r     <= 1'b0;
      ready_r     <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      conflict_r  <= 1'b0;
      drop_r      <= 1'b0;
      state_exp_r <= 1'b0;
`ifdef SRDRV_RETRY_EN
      retry_cnt     <= '0;
      retry_pending <= 1'b0;
`endif
    end else begin
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      conflict_r <= 1'b0;
      drop_r     <= 1'b0;

      // A request that arrives while busy is discarded but reported.
      if (!ready_r && any_req) begin
        drop_r <= 1'b1;
      end

      case (state)
        IDLE: begin
          ready_r <= 1'b1;
          if (ready_r) begin
            if (bus.req_set && bus.req_clr) begin
              conflict_r <= 1'b1;
            end else if (any_req) begin
              state       <= PULSE;
              cnt         <= PULSE_LOAD;
              set_r       <= bus.req_set;
              reset_r     <= bus.req_clr;
              state_exp_r <= bus.req_set;
              ready_r     <= 1'b0;
`ifdef SRDRV_RETRY_EN
              retry_cnt     <= '0;
              retry_pending <= 1'b0;
`endif
            end
          end
        end

        PULSE: begin
          if (cnt_zero) begin
            state   <= SETTLE;
            cnt     <= SETTLE_LOAD;
            set_r   <= 1'b0;
            reset_r <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // The verdict is taken on the last settle edge so done lands in CHECK.
        SETTLE: begin
          if (cnt_zero) begin
            state <= CHECK;
`ifdef SRDRV_RETRY_EN
            if (!readback_ok && (retry_cnt < RETRY_LIMIT)) begin
              retry_pending <= 1'b1;
            end else begin
              retry_pending <= 1'b0;
              done_r        <= 1'b1;
              err_r         <= ~readback_ok;
            end
`else
            done_r <= 1'b1;
            err_r  <= ~readback_ok;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        CHECK: begin
`ifdef SRDRV_RETRY_EN
          if (retry_pending) begin
            state         <= PULSE;
            cnt           <= PULSE_LOAD;
            set_r         <= state_exp_r;
            reset_r       <= ~state_exp_r;
            retry_cnt     <= retry_cnt + 1'b1;
            retry_pending <= 1'b0;
          end else begin
            state <= GAP;
            cnt   <= GAP_LOAD;
          end
`else
          state <= GAP;
          cnt   <= GAP_LOAD;
`endif
        end

        GAP: begin
          if (cnt_zero) begin
            state   <= IDLE;
            ready_r <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          set_r   <= 1'b0;
          reset_r <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.set_out   = set_r;
  assign bus.reset_out = reset_r;
  assign bus.ready     = ready_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.conflict  = conflict_r;
  assign bus.drop      = drop_r;
  assign bus.state_exp = state_exp_r;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural NOR latch attached.
// Each operation records 20 cycles of outputs as bit vectors (bit k = value
// after the k-th edge counting the accept edge as 1) and compares them with
// hand-computed masks.
module tb_sr_latch_driver;

  localparam int NCYC = 20;

  localparam logic [31:0] PULSE_OK   = 32'h0000_0006;
  localparam logic [31:0] DONE_OK    = 32'h0000_0020;
  localparam logic [31:0] READY_OK   = 32'h001F_FF80;
`ifdef SRDRV_RETRY_EN
  localparam logic [31:0] PULSE_BAD  = 32'h0000_18C6;
  localparam logic [31:0] DONE_BAD   = 32'h0000_8000;
  localparam logic [31:0] READY_BAD  = 32'h001E_0000;
`else
  localparam logic [31:0] PULSE_BAD  = 32'h0000_0006;
  localparam logic [31:0] DONE_BAD   = 32'h0000_0020;
  localparam logic [31:0] READY_BAD  = 32'h001F_FF80;
`endif

  logic clk;
  logic rst;

  sr_latch_driver_if bus ();

  sr_latch_driver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests;
  int n_fail;

  logic latch_q;
  logic fault_en;
  logic fault_q;
  logic fault_qb;

  logic [31:0] tv_set, tv_rst, tv_ready, tv_done, tv_err, tv_conf, tv_drop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural NOR latch; set wins only because the driver never overlaps them.
  always @(bus.set_out or bus.reset_out) begin
    if (bus.set_out) latch_q = 1'b1;
    else if (bus.reset_out) latch_q = 1'b0;
  end

  assign bus.q     = fault_en ? fault_q  : latch_q;
  assign bus.q_bar = fault_en ? fault_qb : ~latch_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // The drives must never overlap, in any cycle.
  always @(negedge clk) begin
    check("no_overlap", {31'b0, bus.set_out & bus.reset_out}, 32'd0);
  end

  // Present a request before the accept edge, then record NCYC cycles.
  // drop_at/rst_at: raise req_set / rst after recording that index (0 = never).
  task automatic run_op(input logic s, input logic c, input int drop_at, input int rst_at);
    tv_set = '0; tv_rst = '0; tv_ready = '0; tv_done = '0;
    tv_err = '0; tv_conf = '0; tv_drop = '0;
    @(negedge clk);
    bus.req_set = s;
    bus.req_clr = c;
    for (int k = 1; k <= NCYC; k++) begin
      @(posedge clk);
      @(negedge clk);
      tv_set[k]   = bus.set_out;
      tv_rst[k]   = bus.reset_out;
      tv_ready[k] = bus.ready;
      tv_done[k]  = bus.done;
      tv_err[k]   = bus.err;
      tv_conf[k]  = bus.conflict;
      tv_drop[k]  = bus.drop;
      if (k == 1) begin
        bus.req_set = 1'b0;
        bus.req_clr = 1'b0;
      end
      if (k == drop_at) bus.req_set = 1'b1;
      if (drop_at != 0 && k == drop_at + 1) bus.req_set = 1'b0;
      if (k == rst_at) rst = 1'b1;
      if (rst_at != 0 && k == rst_at + 2) rst = 1'b0;
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    latch_q     = 1'b0;
    fault_en    = 1'b0;
    fault_q     = 1'b0;
    fault_qb    = 1'b0;
    rst         = 1'b1;
    bus.req_set = 1'b0;
    bus.req_clr = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {24'b0, bus.set_out, bus.reset_out, bus.ready, bus.done,
           bus.err, bus.conflict, bus.drop, bus.state_exp}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", {31'b0, bus.ready}, 32'd1);

    // 1) set
    run_op(1'b1, 1'b0, 0, 0);
    check("t1_set_out",   tv_set,   PULSE_OK);
    check("t1_reset_out", tv_rst,   32'd0);
    check("t1_done",      tv_done,  DONE_OK);
    check("t1_err",       tv_err,   32'd0);
    check("t1_ready",     tv_ready, READY_OK);
    check("t1_state_exp", {31'b0, bus.state_exp}, 32'd1);

    // 2) clear
    run_op(1'b0, 1'b1, 0, 0);
    check("t2_reset_out", tv_rst,   PULSE_OK);
    check("t2_set_out",   tv_set,   32'd0);
    check("t2_done",      tv_done,  DONE_OK);
    check("t2_err",       tv_err,   32'd0);
    check("t2_state_exp", {31'b0, bus.state_exp}, 32'd0);

    // 3) conflicting requests
    run_op(1'b1, 1'b1, 0, 0);
    check("t3_conflict",  tv_conf,  32'h0000_0002);
    check("t3_set_out",   tv_set,   32'd0);
    check("t3_reset_out", tv_rst,   32'd0);
    check("t3_done",      tv_done,  32'd0);
    check("t3_ready",     tv_ready, 32'h001F_FFFE);

    // 4) request while busy
    run_op(1'b1, 1'b0, 2, 0);
    check("t4_drop",      tv_drop,  32'h0000_0008);
    check("t4_set_out",   tv_set,   PULSE_OK);
    check("t4_done",      tv_done,  DONE_OK);
    check("t4_err",       tv_err,   32'd0);
    check("t4_ready",     tv_ready, READY_OK);

    // 5) set with latch stuck at q=0,q_bar=1
    fault_en = 1'b1; fault_q = 1'b0; fault_qb = 1'b1;
    run_op(1'b1, 1'b0, 0, 0);
    check("t5_set_out",   tv_set,   PULSE_BAD);
    check("t5_done",      tv_done,  DONE_BAD);
    check("t5_err",       tv_err,   DONE_BAD);
    check("t5_ready",     tv_ready, READY_BAD);
    check("t5_state_exp", {31'b0, bus.state_exp}, 32'd1);

    // 6) clear with readback 11
    fault_q = 1'b1; fault_qb = 1'b1;
    run_op(1'b0, 1'b1, 0, 0);
    check("t6_reset_out", tv_rst,   PULSE_BAD);
    check("t6_set_out",   tv_set,   32'd0);
    check("t6_err",       tv_err,   DONE_BAD);
    check("t6_done",      tv_done,  DONE_BAD);

    // 7) set with readback 00
    fault_q = 1'b0; fault_qb = 1'b0;
    run_op(1'b1, 1'b0, 0, 0);
    check("t7_err",       tv_err,   DONE_BAD);
    check("t7_done",      tv_done,  DONE_BAD);
    fault_en = 1'b0;

    // 8) reset during the pulse
    run_op(1'b1, 1'b0, 0, 1);
    check("t8_set_out",   tv_set,   32'h0000_0002);
    check("t8_done",      tv_done,  32'd0);
    check("t8_ready",     tv_ready, 32'h001F_FFF0);
    check("t8_state_exp", {31'b0, bus.state_exp}, 32'd0);

    // 9) normal operation resumes after the interrupted one
    run_op(1'b0, 1'b1, 0, 0);
    check("t9_reset_out", tv_rst,   PULSE_OK);
    check("t9_done",      tv_done,  DONE_OK);
    check("t9_err",       tv_err,   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
